// File: rtl/icache_ctrl_pkg.sv
// Shared state encoding and line/beat geometry for the instruction-cache refill controller.
`ifndef ICACHE_DATA_BLOCK_SIZE
`define ICACHE_DATA_BLOCK_SIZE 64
`endif
`ifndef ICACHE_WRITE_SIZE_BITS
`define ICACHE_WRITE_SIZE_BITS 64
`endif

package icache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    localparam int ICACHE_BLOCK_BITS = `ICACHE_DATA_BLOCK_SIZE;
    localparam int ICACHE_WRITE_BITS = `ICACHE_WRITE_SIZE_BITS;
    localparam int LINE_OFFSET_BITS  = $clog2(ICACHE_BLOCK_BITS / 8);
    localparam int BEAT_BYTE_STRIDE  = ICACHE_WRITE_BITS / 8;

    // A beat counter must hold NUM_BEATS values but is never narrower than one bit.
    function automatic int beat_cnt_width(input int num_beats);
        return (num_beats > 1) ? $clog2(num_beats) : 1;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: serves hits combinationally, refills missing lines from DRAM
// and owns the cache address / write-data / write-enable muxing.
module icache_refill_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_BITS = ICACHE_BLOCK_BITS,
    parameter int WRITE_BITS = ICACHE_WRITE_BITS,
    parameter int NUM_BEATS  = BLOCK_BITS / WRITE_BITS
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_flush,
    output logic                  fetch_resp_valid,
    output logic [BLOCK_BITS-1:0] fetch_resp_data,
    output logic                  fetch_stall,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_we_aL,
    output logic [WRITE_BITS-1:0] cache_write_data,
    input  logic [BLOCK_BITS-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  dram_req_valid,
    input  logic                  dram_req_ready,
    output logic [ADDR_WIDTH-1:0] dram_req_addr,
    input  logic                  dram_resp_valid,
    input  logic [WRITE_BITS-1:0] dram_resp_data
);

    localparam int                    CNT_W       = beat_cnt_width(NUM_BEATS);
    localparam int                    OFF_BITS    = $clog2(BLOCK_BITS / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK   = ~ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STRIDE = ADDR_WIDTH'(WRITE_BITS / 8);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(NUM_BEATS - 1);

    refill_state_t         state;
    refill_state_t         state_nxt;
    logic [CNT_W-1:0]      beat_cnt;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic                  drop;

    logic miss;
    logic req_fire;
    logic beat_fire;
    logic last_beat;

    // DRAM request: dram_req_valid rises in REQ and holds with a stable address until the cycle
    // dram_req_ready is seen high; that cycle is the transfer. Response beats carry no backpressure.
    assign miss      = (state == IDLE) && fetch_valid && !cache_hit && !fetch_flush;
    assign req_fire  = (state == REQ) && dram_req_ready;
    assign beat_fire = (state == WAIT) && dram_resp_valid;
    assign last_beat = beat_fire && (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (miss) state_nxt = REQ;
            REQ: begin
                // A flush on the handshake cycle loses: the request is already committed.
                if (req_fire)         state_nxt = WAIT;
                else if (fetch_flush) state_nxt = IDLE;
            end
            WAIT: if (last_beat) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            beat_cnt  <= '0;
            miss_addr <= '0;
            drop      <= 1'b0;
        end else begin
            if (miss) miss_addr <= fetch_addr & LINE_MASK;
            if (req_fire)       beat_cnt <= '0;
            else if (beat_fire) beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
            // A flushed refill still completes so the line ends up valid; only the reply is dropped.
            drop <= (state == WAIT) && (drop || fetch_flush);
        end
    end

    always_comb begin
        fetch_resp_valid = 1'b0;
        fetch_resp_data  = '0;
        fetch_stall      = 1'b0;
        cache_addr       = '0;
        cache_we_aL      = 1'b1;
        cache_write_data = '0;
        dram_req_valid   = 1'b0;
        dram_req_addr    = '0;
        if (rst_aL) begin
            case (state)
                IDLE: begin
                    cache_addr       = fetch_addr;
                    fetch_resp_valid = fetch_valid && cache_hit && !fetch_flush;
                    fetch_resp_data  = cache_rdata;
                end
                REQ: begin
                    fetch_stall    = 1'b1;
                    cache_addr     = miss_addr;
                    dram_req_valid = 1'b1;
                    dram_req_addr  = miss_addr;
                end
                WAIT: begin
                    fetch_stall = 1'b1;
                    cache_addr  = miss_addr;
                    if (dram_resp_valid) begin
                        cache_we_aL      = 1'b0;
                        cache_write_data = dram_resp_data;
                        cache_addr       = miss_addr + ADDR_WIDTH'(beat_cnt) * BEAT_STRIDE;
                    end
                end
                DONE: begin
                    fetch_stall = 1'b1;
                    cache_addr  = miss_addr;
                end
                default: begin
                    fetch_stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a single-beat instance backed by a small line store
// and a two-beat instance (32-bit beats) exercised for beat ordering.
module tb_icache_refill_ctrl;

    logic clk;
    logic rst_aL;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-beat instance
    logic        fetch_valid, fetch_flush, fetch_resp_valid, fetch_stall;
    logic [31:0] fetch_addr, cache_addr, dram_req_addr;
    logic [63:0] fetch_resp_data, cache_write_data, cache_rdata, dram_resp_data;
    logic        cache_we_aL, cache_hit, dram_req_valid, dram_req_ready, dram_resp_valid;

    // two-beat instance
    logic        m_fetch_valid, m_fetch_flush, m_fetch_resp_valid, m_fetch_stall;
    logic [31:0] m_fetch_addr, m_cache_addr, m_dram_req_addr;
    logic [63:0] m_fetch_resp_data, m_cache_rdata;
    logic [31:0] m_cache_write_data, m_dram_resp_data;
    logic        m_cache_we_aL, m_cache_hit, m_dram_req_valid, m_dram_req_ready, m_dram_resp_valid;

    icache_refill_ctrl #(.ADDR_WIDTH(32), .BLOCK_BITS(64), .WRITE_BITS(64)) u_dut (
        .clk(clk), .rst_aL(rst_aL),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
        .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
        .fetch_stall(fetch_stall), .cache_addr(cache_addr), .cache_we_aL(cache_we_aL),
        .cache_write_data(cache_write_data), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
        .dram_req_addr(dram_req_addr), .dram_resp_valid(dram_resp_valid),
        .dram_resp_data(dram_resp_data)
    );

    icache_refill_ctrl #(.ADDR_WIDTH(32), .BLOCK_BITS(64), .WRITE_BITS(32)) u_dut2 (
        .clk(clk), .rst_aL(rst_aL),
        .fetch_valid(m_fetch_valid), .fetch_addr(m_fetch_addr), .fetch_flush(m_fetch_flush),
        .fetch_resp_valid(m_fetch_resp_valid), .fetch_resp_data(m_fetch_resp_data),
        .fetch_stall(m_fetch_stall), .cache_addr(m_cache_addr), .cache_we_aL(m_cache_we_aL),
        .cache_write_data(m_cache_write_data), .cache_rdata(m_cache_rdata),
        .cache_hit(m_cache_hit), .dram_req_valid(m_dram_req_valid),
        .dram_req_ready(m_dram_req_ready), .dram_req_addr(m_dram_req_addr),
        .dram_resp_valid(m_dram_resp_valid), .dram_resp_data(m_dram_resp_data)
    );

    // line store: 16 direct-mapped 8-byte lines, or table-driven hit/data when use_model=0
    logic        use_model, tv_hit, model_clr, pre_en;
    logic [63:0] tv_rdata, pre_data;
    logic [31:0] pre_addr;
    logic        mvalid [16];
    logic [24:0] mtag   [16];
    logic [63:0] mdata  [16];
    logic [3:0]  midx;

    assign midx        = cache_addr[6:3];
    assign cache_hit   = use_model ? (mvalid[midx] && (mtag[midx] == cache_addr[31:7])) : tv_hit;
    assign cache_rdata = use_model ? mdata[midx] : tv_rdata;

    // scoreboard: {instance id, cache_addr, write data zero-extended to 64}
    localparam int SW = 97;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] obs_q[$];

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 16; i++) begin
                mvalid[i] <= 1'b0;
                mtag[i]   <= '0;
                mdata[i]  <= '0;
            end
        end else if (pre_en) begin
            mvalid[pre_addr[6:3]] <= 1'b1;
            mtag[pre_addr[6:3]]   <= pre_addr[31:7];
            mdata[pre_addr[6:3]]  <= pre_data;
        end
        if (!cache_we_aL) begin
            mvalid[cache_addr[6:3]] <= 1'b1;
            mtag[cache_addr[6:3]]   <= cache_addr[31:7];
            mdata[cache_addr[6:3]]  <= cache_write_data;
            obs_q.push_back({1'b0, cache_addr, cache_write_data});
        end
        if (!m_cache_we_aL) obs_q.push_back({1'b1, m_cache_addr, 32'h0, m_cache_write_data});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_writes(input string name);
        chk({name, "_write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_w%0d_addr", name, i), 64'(obs_q[i][96:64]), 64'(exp_q[i][96:64]));
            chk($sformatf("%s_w%0d_data", name, i), obs_q[i][63:0], exp_q[i][63:0]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    typedef struct {
        logic        fv;
        logic [31:0] addr;
        logic        flush;
        logic        hit;
        logic [63:0] rdata;
        logic        exp_rv;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0044, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[1] = '{1'b1, 32'h0000_0044, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0080, 1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_2000, 1'b1, 1'b0, 64'h6666_0000_6666_0000, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b1};

        // reset with live inputs: every output must still sit at its reset value
        rst_aL = 1'b0; model_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        use_model = 1'b0; tv_hit = 1'b1; tv_rdata = 64'h0123_4567_89AB_CDEF;
        fetch_valid = 1'b1; fetch_addr = 32'h44; fetch_flush = 1'b0;
        dram_req_ready = 1'b0; dram_resp_valid = 1'b1; dram_resp_data = 64'h99;
        m_fetch_valid = 1'b1; m_fetch_addr = 32'h804; m_fetch_flush = 1'b0;
        m_cache_hit = 1'b0; m_cache_rdata = '0; m_dram_req_ready = 1'b1;
        m_dram_resp_valid = 1'b1; m_dram_resp_data = 32'h1;
        tick(); tick();
        #1;
        chk("rst_resp_valid", 64'(fetch_resp_valid), 64'd0);
        chk("rst_stall", 64'(fetch_stall), 64'd0);
        chk("rst_we_aL", 64'(cache_we_aL), 64'd1);
        chk("rst_req_valid", 64'(dram_req_valid), 64'd0);
        chk("rst_req_addr", 64'(dram_req_addr), 64'd0);
        chk("rst_cache_addr", 64'(cache_addr), 64'd0);
        chk("rst_wdata", cache_write_data, 64'd0);
        chk("rst_m_we_aL", 64'(m_cache_we_aL), 64'd1);
        chk("rst_m_cache_addr", 64'(m_cache_addr), 64'd0);

        tick();
        rst_aL = 1'b1; model_clr = 1'b0;
        fetch_valid = 1'b0; dram_resp_valid = 1'b0;
        m_fetch_valid = 1'b0; m_dram_req_ready = 1'b0; m_dram_resp_valid = 1'b0;

        // IDLE lookups straight from the vector table
        for (int i = 0; i < 6; i++) begin
            tick();
            fetch_valid = vecs[i].fv; fetch_addr = vecs[i].addr; fetch_flush = vecs[i].flush;
            tv_hit = vecs[i].hit; tv_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_resp_valid", i), 64'(fetch_resp_valid), 64'(vecs[i].exp_rv));
            chk($sformatf("v%0d_resp_data", i), fetch_resp_data, vecs[i].rdata);
            chk($sformatf("v%0d_stall", i), 64'(fetch_stall), 64'd0);
            chk($sformatf("v%0d_req_valid", i), 64'(dram_req_valid), 64'd0);
            chk($sformatf("v%0d_cache_addr", i), 64'(cache_addr), 64'(vecs[i].addr));
            chk($sformatf("v%0d_we_aL", i), 64'(cache_we_aL), 64'd1);
            fetch_valid = 1'b0; fetch_flush = 1'b0;
        end

        // hit on a preloaded line
        tick();
        pre_en = 1'b1; pre_addr = 32'h40; pre_data = 64'h0123_4567_89AB_CDEF;
        tick();
        pre_en = 1'b0; use_model = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'h44;
        #1;
        chk("hit_resp_valid", 64'(fetch_resp_valid), 64'd1);
        chk("hit_resp_data", fetch_resp_data, 64'h0123_4567_89AB_CDEF);
        chk("hit_stall", 64'(fetch_stall), 64'd0);
        chk("hit_req_valid", 64'(dram_req_valid), 64'd0);

        // cold miss at 0x104, request accepted on its third cycle, beat five cycles later
        tick();
        fetch_addr = 32'h104;
        #1;
        chk("miss_c0_resp_valid", 64'(fetch_resp_valid), 64'd0);
        chk("miss_c0_cache_addr", 64'(cache_addr), 64'h104);
        for (int c = 1; c <= 3; c++) begin
            tick();
            dram_req_ready = (c == 3);
            #1;
            chk($sformatf("miss_c%0d_stall", c), 64'(fetch_stall), 64'd1);
            chk($sformatf("miss_c%0d_req_valid", c), 64'(dram_req_valid), 64'd1);
            chk($sformatf("miss_c%0d_req_addr", c), 64'(dram_req_addr), 64'h100);
            chk($sformatf("miss_c%0d_we_aL", c), 64'(cache_we_aL), 64'd1);
        end
        for (int c = 4; c <= 7; c++) begin
            tick();
            dram_req_ready = 1'b0;
            #1;
            chk($sformatf("miss_c%0d_stall", c), 64'(fetch_stall), 64'd1);
            chk($sformatf("miss_c%0d_req_valid", c), 64'(dram_req_valid), 64'd0);
            chk($sformatf("miss_c%0d_we_aL", c), 64'(cache_we_aL), 64'd1);
            chk($sformatf("miss_c%0d_cache_addr", c), 64'(cache_addr), 64'h100);
        end
        tick();
        dram_resp_valid = 1'b1; dram_resp_data = 64'hDEAD_BEEF_CAFE_F00D;
        exp_q.push_back({1'b0, 32'h100, 64'hDEAD_BEEF_CAFE_F00D});
        #1;
        chk("miss_beat_we_aL", 64'(cache_we_aL), 64'd0);
        chk("miss_beat_cache_addr", 64'(cache_addr), 64'h100);
        chk("miss_beat_wdata", cache_write_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("miss_beat_resp_valid", 64'(fetch_resp_valid), 64'd0);
        tick();
        dram_resp_valid = 1'b0;
        #1;
        chk("miss_done_stall", 64'(fetch_stall), 64'd1);
        chk("miss_done_we_aL", 64'(cache_we_aL), 64'd1);
        chk("miss_done_cache_addr", 64'(cache_addr), 64'h100);
        chk("miss_done_resp_valid", 64'(fetch_resp_valid), 64'd0);
        tick();
        #1;
        chk("miss_replay_stall", 64'(fetch_stall), 64'd0);
        chk("miss_replay_resp_valid", 64'(fetch_resp_valid), 64'd1);
        chk("miss_replay_resp_data", fetch_resp_data, 64'hDEAD_BEEF_CAFE_F00D);
        check_writes("refill");
        fetch_valid = 1'b0;

        // flush while the request is still pending: back to IDLE, nothing issued or written
        tick();
        fetch_valid = 1'b1; fetch_addr = 32'h200;
        tick();
        #1;
        chk("freq_req_valid", 64'(dram_req_valid), 64'd1);
        chk("freq_req_addr", 64'(dram_req_addr), 64'h200);
        fetch_flush = 1'b1; fetch_valid = 1'b0;
        tick();
        fetch_flush = 1'b0; dram_req_ready = 1'b1;
        #1;
        chk("freq_after_stall", 64'(fetch_stall), 64'd0);
        chk("freq_after_req_valid", 64'(dram_req_valid), 64'd0);
        tick();
        dram_req_ready = 1'b0;
        #1;
        chk("freq_idle_stall", 64'(fetch_stall), 64'd0);
        check_writes("flush_req");

        // flush on the handshake cycle: request stands, line is written
        tick();
        fetch_valid = 1'b1; fetch_addr = 32'h500;
        tick();
        #1;
        chk("fhs_req_valid", 64'(dram_req_valid), 64'd1);
        dram_req_ready = 1'b1; fetch_flush = 1'b1; fetch_valid = 1'b0;
        tick();
        dram_req_ready = 1'b0; fetch_flush = 1'b0;
        dram_resp_valid = 1'b1; dram_resp_data = 64'h22;
        exp_q.push_back({1'b0, 32'h500, 64'h22});
        #1;
        chk("fhs_wait_stall", 64'(fetch_stall), 64'd1);
        chk("fhs_beat_we_aL", 64'(cache_we_aL), 64'd0);
        chk("fhs_beat_cache_addr", 64'(cache_addr), 64'h500);
        tick();
        dram_resp_valid = 1'b0;
        #1;
        chk("fhs_done_stall", 64'(fetch_stall), 64'd1);
        tick();
        #1;
        chk("fhs_idle_stall", 64'(fetch_stall), 64'd0);
        check_writes("flush_handshake");

        // flush while waiting for data: line still filled, no response given
        tick();
        fetch_valid = 1'b1; fetch_addr = 32'h300;
        tick();
        dram_req_ready = 1'b1;
        #1;
        chk("fwait_req_valid", 64'(dram_req_valid), 64'd1);
        tick();
        dram_req_ready = 1'b0; fetch_flush = 1'b1; fetch_valid = 1'b0;
        #1;
        chk("fwait_stall", 64'(fetch_stall), 64'd1);
        chk("fwait_resp_valid", 64'(fetch_resp_valid), 64'd0);
        tick();
        fetch_flush = 1'b0; dram_resp_valid = 1'b1; dram_resp_data = 64'h11;
        exp_q.push_back({1'b0, 32'h300, 64'h11});
        #1;
        chk("fwait_beat_we_aL", 64'(cache_we_aL), 64'd0);
        chk("fwait_beat_cache_addr", 64'(cache_addr), 64'h300);
        chk("fwait_beat_wdata", cache_write_data, 64'h11);
        tick();
        dram_resp_valid = 1'b0;
        #1;
        chk("fwait_done_stall", 64'(fetch_stall), 64'd1);
        chk("fwait_done_resp_valid", 64'(fetch_resp_valid), 64'd0);
        tick();
        #1;
        chk("fwait_idle_stall", 64'(fetch_stall), 64'd0);
        chk("fwait_idle_resp_valid", 64'(fetch_resp_valid), 64'd0);
        check_writes("flush_wait");
        tick();
        fetch_valid = 1'b1; fetch_addr = 32'h300;
        #1;
        chk("fwait_line_hit", 64'(fetch_resp_valid), 64'd1);
        chk("fwait_line_data", fetch_resp_data, 64'h11);
        fetch_valid = 1'b0;

        // two 32-bit beats per line; stray beat in IDLE must not write
        tick();
        m_dram_resp_valid = 1'b1; m_dram_resp_data = 32'hDEAD_0001;
        #1;
        chk("mb_stray_we_aL", 64'(m_cache_we_aL), 64'd1);
        tick();
        m_dram_resp_valid = 1'b0; m_fetch_valid = 1'b1; m_fetch_addr = 32'h80C;
        #1;
        chk("mb_c0_stall", 64'(m_fetch_stall), 64'd0);
        tick();
        m_fetch_valid = 1'b0; m_dram_req_ready = 1'b1;
        #1;
        chk("mb_req_valid", 64'(m_dram_req_valid), 64'd1);
        chk("mb_req_addr", 64'(m_dram_req_addr), 64'h808);
        tick();
        m_dram_req_ready = 1'b0; m_dram_resp_valid = 1'b1; m_dram_resp_data = 32'hAAAA_0000;
        exp_q.push_back({1'b1, 32'h808, 32'h0, 32'hAAAA_0000});
        #1;
        chk("mb_b0_we_aL", 64'(m_cache_we_aL), 64'd0);
        chk("mb_b0_cache_addr", 64'(m_cache_addr), 64'h808);
        chk("mb_b0_wdata", 64'(m_cache_write_data), 64'hAAAA_0000);
        tick();
        m_dram_resp_valid = 1'b0;
        #1;
        chk("mb_gap_we_aL", 64'(m_cache_we_aL), 64'd1);
        chk("mb_gap_cache_addr", 64'(m_cache_addr), 64'h808);
        chk("mb_gap_stall", 64'(m_fetch_stall), 64'd1);
        tick();
        m_dram_resp_valid = 1'b1; m_dram_resp_data = 32'hBBBB_1111;
        exp_q.push_back({1'b1, 32'h80C, 32'h0, 32'hBBBB_1111});
        #1;
        chk("mb_b1_we_aL", 64'(m_cache_we_aL), 64'd0);
        chk("mb_b1_cache_addr", 64'(m_cache_addr), 64'h80C);
        chk("mb_b1_wdata", 64'(m_cache_write_data), 64'hBBBB_1111);
        tick();
        m_dram_resp_valid = 1'b0;
        #1;
        chk("mb_done_stall", 64'(m_fetch_stall), 64'd1);
        chk("mb_done_we_aL", 64'(m_cache_we_aL), 64'd1);
        chk("mb_done_cache_addr", 64'(m_cache_addr), 64'h808);
        chk("mb_done_resp_valid", 64'(m_fetch_resp_valid), 64'd0);
        tick();
        m_dram_resp_valid = 1'b1; m_dram_resp_data = 32'hCCCC_2222;
        #1;
        chk("mb_idle_stall", 64'(m_fetch_stall), 64'd0);
        chk("mb_idle_stray_we_aL", 64'(m_cache_we_aL), 64'd1);
        tick();
        m_dram_resp_valid = 1'b0;
        check_writes("multi_beat");

        // asynchronous reset in the middle of a WAIT cycle
        tick();
        fetch_valid = 1'b1; fetch_addr = 32'h600;
        tick();
        dram_req_ready = 1'b1;
        #1;
        chk("arst_req_valid", 64'(dram_req_valid), 64'd1);
        tick();
        dram_req_ready = 1'b0;
        #1;
        chk("arst_wait_stall", 64'(fetch_stall), 64'd1);
        #2;
        rst_aL = 1'b0; dram_resp_valid = 1'b1; dram_resp_data = 64'h77;
        #1;
        chk("arst_resp_valid", 64'(fetch_resp_valid), 64'd0);
        chk("arst_stall", 64'(fetch_stall), 64'd0);
        chk("arst_we_aL", 64'(cache_we_aL), 64'd1);
        chk("arst_req_valid_low", 64'(dram_req_valid), 64'd0);
        chk("arst_cache_addr", 64'(cache_addr), 64'd0);
        chk("arst_wdata", cache_write_data, 64'd0);
        tick();
        rst_aL = 1'b1; fetch_valid = 1'b0;
        #1;
        chk("arst_late_we_aL", 64'(cache_we_aL), 64'd1);
        chk("arst_late_stall", 64'(fetch_stall), 64'd0);
        tick();
        dram_resp_valid = 1'b0;
        #1;
        chk("arst_after_req_valid", 64'(dram_req_valid), 64'd0);
        check_writes("async_reset");

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-handling controller between the fetch stage, the instruction cache array (`cache`, ICACHE_* params) and the DRAM port.
- Services fetch lookups combinationally on a hit.
- On a miss: stalls fetch, issues a line-aligned DRAM request, writes the returned beats into the cache via its active-low write enable, then replays the lookup.
- Owns the cache address/write-data/we_aL muxing so that fetch never drives the array directly.

Parameters:
ADDR_WIDTH, 32, fetch/DRAM byte address width
BLOCK_BITS, `ICACHE_DATA_BLOCK_SIZE (64), cache line size in bits
WRITE_BITS, `ICACHE_WRITE_SIZE_BITS (64), bits per DRAM response beat / cache write
NUM_BEATS, BLOCK_BITS/WRITE_BITS (1), beats per refill; must be a power of two, ≥1

Ports:
clk  in  1  single clock, rising edge
rst_aL  in  1  asynchronous active-low reset
fetch_valid  in  1  fetch lookup request this cycle
fetch_addr  in  ADDR_WIDTH  fetch PC
fetch_flush  in  1  redirect; abandon the current request
fetch_resp_valid  out  1  fetch_resp_data is the line for fetch_addr
fetch_resp_data  out  BLOCK_BITS  selected cache line
fetch_stall  out  1  controller busy with a refill
cache_addr  out  ADDR_WIDTH  address to cache
cache_we_aL  out  1  cache write enable, active low
cache_write_data  out  WRITE_BITS  cache write data
cache_rdata  in  BLOCK_BITS  cache selected_data_way
cache_hit  in  1  cache hit
dram_req_valid  out  1  DRAM read request
dram_req_ready  in  1  DRAM accepts request
dram_req_addr  out  ADDR_WIDTH  line-aligned request address
dram_resp_valid  in  1  response beat valid
dram_resp_data  in  WRITE_BITS  response beat

Behaviour:
- Reset (async, rst_aL=0):
  - state=IDLE, beat_cnt=0, miss_addr=0.
  - Outputs: fetch_resp_valid=0, fetch_stall=0, cache_we_aL=1, dram_req_valid=0, dram_req_addr=0, cache_addr=0, cache_write_data=0.
  - Reset mid-refill abandons the refill; later DRAM beats are ignored.
- IDLE:
  - cache_addr=fetch_addr.
  - fetch_resp_valid = fetch_valid & cache_hit & ~fetch_flush (combinational, 0-cycle hit latency).
  - fetch_resp_data=cache_rdata.
  - Miss (fetch_valid & ~cache_hit & ~fetch_flush): latch miss_addr = fetch_addr with the low log2(BLOCK_BITS/8) bits cleared, then go to REQ.
- REQ:
  - fetch_stall=1, dram_req_valid=1, dram_req_addr=miss_addr; hold all three until the handshake.
  - dram_req_valid & dram_req_ready -> WAIT, beat_cnt=0.
  - fetch_flush in REQ before the handshake -> IDLE with no request issued. A flush coinciding with the handshake goes to WAIT, because the request is already committed.
- WAIT:
  - fetch_stall=1.
  - Each dram_resp_valid cycle:
    - cache_we_aL=0, cache_write_data=dram_resp_data.
    - cache_addr = miss_addr + beat_cnt*(WRITE_BITS/8).
    - beat_cnt++.
  - Write on the beat where beat_cnt==NUM_BEATS-1 -> DONE.
  - Cycles without dram_resp_valid: cache_we_aL=1, cache_addr=miss_addr.
  - fetch_flush in WAIT sets a sticky drop flag. The line is still written in full (it stays valid), but no response is given.
- DONE:
  - One cycle, cache_addr=miss_addr, fetch_stall=1, then IDLE (drop flag cleared).
  - Fetch re-presents its PC and hits in IDLE.
- dram_resp_valid outside WAIT is ignored: no write, no counter change.
- beat_cnt is log2(NUM_BEATS) bits wide, minimum 1, and wraps to 0 on entering DONE.
- cache_we_aL is low only in WAIT on a valid beat, never for more than NUM_BEATS cycles per refill.
- dram_req_valid is never asserted outside REQ. Exactly one request is issued per miss.

Decomposition:
- Shared package icache_ctrl_pkg holds:
  - state typedef {IDLE, REQ, WAIT, DONE};
  - LINE_OFFSET_BITS and beat-byte-stride constants derived from the ICACHE_* globals.
- A single module with no sub-module; the `cache` instance lives in the fetch top alongside it.

Test Plan:
- Hit: preload line 0x40 with 0x0123456789ABCDEF; fetch_addr=0x44, fetch_valid=1 -> same-cycle fetch_resp_valid=1, data=0x0123456789ABCDEF, fetch_stall=0, dram_req_valid=0.
- Miss/refill:
  - Stimulus: cold fetch_addr=0x104; dram_req_ready after 3 cycles; resp beat 0xDEADBEEFCAFEF00D 5 cycles later.
  - Response: dram_req_addr=0x100 held 3 cycles; one cycle of cache_we_aL=0 at cache_addr=0x100; DONE; next IDLE lookup hits with 0xDEADBEEFCAFEF00D; fetch_stall high from cycle 1 through DONE.
- Flush in REQ: miss at 0x200, fetch_flush before dram_req_ready -> IDLE next cycle, no handshake, no cache write.
- Flush in WAIT: miss at 0x300, flush after handshake, beat 0x11 -> line written at 0x300, fetch_resp_valid stays 0, returns to IDLE.
- Multi-beat (NUM_BEATS=2, WRITE_BITS=32): beats 0xAAAA0000, 0xBBBB1111 -> writes at miss_addr and miss_addr+4 in order; a spurious dram_resp_valid in IDLE causes no write.
- Async reset: drop rst_aL in WAIT mid-clock -> all outputs at reset values immediately; a late beat after release produces no write.
